// File: rtl/branch_resolve_unit_if.sv
// Handshake bundle between the pipeline and the branch resolve unit.
// The pipeline side drives requests/responses; the unit side drives tags, kills, redirects, updates.
interface branch_resolve_unit_if #(
    parameter int SPEC_STATES = 4,
    parameter int ROB_IDX_W   = 6
);
    logic                   Flush;
    logic                   Alloc_Req;
    logic                   Resp_Valid;
    logic [63:0]            Resp_PC;
    logic [63:0]            Resp_Target;
    logic                   Resp_Taken;
    logic                   Resp_Mispred;
    logic                   Resp_IsSpec;
    logic [SPEC_STATES-1:0] Resp_Spectag;
    logic [2:0]             Resp_BrType;
    logic [ROB_IDX_W-1:0]   Resp_RobIdx;
    logic                   Upd_Ready;

    logic                   Alloc_Grant;
    logic [SPEC_STATES-1:0] Alloc_Tag;
    logic                   Alloc_Full;
    logic [SPEC_STATES-1:0] Spectag_Valid;
    logic                   Kill_Enable;
    logic [SPEC_STATES-1:0] Kill_VKillMask;
    logic                   Redirect_Valid;
    logic [63:0]            Redirect_PC;
    logic [ROB_IDX_W-1:0]   Redirect_RobIdx;
    logic                   Upd_Valid;
    logic [130:0]           Upd_Data;
    logic                   Upd_Drop;

    modport master (
        output Flush, Alloc_Req, Resp_Valid, Resp_PC, Resp_Target, Resp_Taken, Resp_Mispred,
               Resp_IsSpec, Resp_Spectag, Resp_BrType, Resp_RobIdx, Upd_Ready,
        input  Alloc_Grant, Alloc_Tag, Alloc_Full, Spectag_Valid, Kill_Enable, Kill_VKillMask,
               Redirect_Valid, Redirect_PC, Redirect_RobIdx, Upd_Valid, Upd_Data, Upd_Drop
    );

    modport slave (
        input  Flush, Alloc_Req, Resp_Valid, Resp_PC, Resp_Target, Resp_Taken, Resp_Mispred,
               Resp_IsSpec, Resp_Spectag, Resp_BrType, Resp_RobIdx, Upd_Ready,
        output Alloc_Grant, Alloc_Tag, Alloc_Full, Spectag_Valid, Kill_Enable, Kill_VKillMask,
               Redirect_Valid, Redirect_PC, Redirect_RobIdx, Upd_Valid, Upd_Data, Upd_Drop
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Speculation-tag allocator with dependency masks, kill/redirect generation on mispredicts,
// and a small FIFO that buffers predictor updates.
module branch_resolve_unit #(
    parameter int SPEC_STATES = 4,
    parameter int ROB_IDX_W   = 6,
    parameter int UPD_DEPTH   = 4
) (
    input logic                clk,
    input logic                rst,
    branch_resolve_unit_if.slave bru
);
    localparam int S     = SPEC_STATES;
    localparam int UPD_W = 131;
    localparam int PTR_W = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;
    localparam int CNT_W = $clog2(UPD_DEPTH + 1);

    logic [S-1:0]          valid_q, valid_d;
    logic [S-1:0][S-1:0]   dep_q, dep_d;
    logic                  kill_en_q, kill_en_d;
    logic [S-1:0]          kill_mask_q, kill_mask_d;
    logic                  redir_valid_q, redir_valid_d;
    logic [63:0]           redir_pc_q, redir_pc_d;
    logic [ROB_IDX_W-1:0]  redir_rob_q, redir_rob_d;
    logic                  drop_q, drop_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [UPD_W-1:0]      mem_q [UPD_DEPTH];

    logic [S-1:0]          alloc_tag, kill_set, freed;
    logic                  full, grant, live, stale, mispred_resolve;
    logic                  push, push_ok, pop, fifo_full;
    logic [UPD_W-1:0]      upd_in;
    logic                  unused_lsbs;

    // Bit 0 of PC/target is always zero for aligned instructions, so it is not stored.
    assign upd_in      = {bru.Resp_PC[63:1], bru.Resp_Target[63:1], bru.Resp_Taken,
                          bru.Resp_Mispred, bru.Resp_BrType};
    assign unused_lsbs = ^{bru.Resp_PC[0], bru.Resp_Target[0]};

    assign live  = bru.Resp_Valid & bru.Resp_IsSpec & |(bru.Resp_Spectag & valid_q);
    assign stale = bru.Resp_Valid & bru.Resp_IsSpec & ~|(bru.Resp_Spectag & valid_q);
    assign mispred_resolve = live & bru.Resp_Mispred;
    assign full  = &valid_q;
    assign grant = bru.Alloc_Req & ~full & ~bru.Flush & ~mispred_resolve;

    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        alloc_tag = '0;
        for (int i = S - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                alloc_tag    = '0;
                alloc_tag[i] = 1'b1;
            end
        end
        kill_set = bru.Resp_Spectag;
        for (int i = 0; i < S; i++) begin
            if (|(dep_q[i] & bru.Resp_Spectag)) kill_set[i] = 1'b1;
        end
        kill_set = kill_set & valid_q;
    end

    always_comb begin
        freed = '0;
        if (mispred_resolve)  freed = kill_set;
        else if (live)        freed = bru.Resp_Spectag & valid_q;

        valid_d = valid_q & ~freed;
        for (int i = 0; i < S; i++) dep_d[i] = dep_q[i] & ~freed;
        if (grant) begin
            valid_d = valid_d | alloc_tag;
            for (int i = 0; i < S; i++) begin
                if (alloc_tag[i]) dep_d[i] = valid_q & ~freed & ~alloc_tag;
            end
        end
        if (bru.Flush) begin
            valid_d = '0;
            dep_d   = '0;
        end

        kill_en_d     = mispred_resolve & ~bru.Flush;
        kill_mask_d   = kill_en_d ? kill_set : '0;
        redir_valid_d = bru.Resp_Valid & bru.Resp_Mispred & ~stale & ~bru.Flush;
        redir_pc_d    = redir_valid_d ? {bru.Resp_Target[63:1], 1'b0} : redir_pc_q;
        redir_rob_d   = redir_valid_d ? bru.Resp_RobIdx : redir_rob_q;
    end

    // Flush suppresses the enqueue but leaves entries already buffered untouched.
    assign fifo_full = (cnt_q == CNT_W'(UPD_DEPTH));
    assign pop       = (cnt_q != '0) & bru.Upd_Ready;
    assign push      = bru.Resp_Valid & ~stale & ~bru.Flush;
    assign push_ok   = push & (~fifo_full | pop);

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        cnt_d    = cnt_q;
        if (push_ok && !pop)      cnt_d = cnt_q + CNT_W'(1);
        else if (!push_ok && pop) cnt_d = cnt_q - CNT_W'(1);
        drop_d   = push & fifo_full & ~pop;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q       <= '0;
            dep_q         <= '0;
            kill_en_q     <= 1'b0;
            kill_mask_q   <= '0;
            redir_valid_q <= 1'b0;
            redir_pc_q    <= '0;
            redir_rob_q   <= '0;
            drop_q        <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            cnt_q         <= '0;
        end else begin
            valid_q       <= valid_d;
            dep_q         <= dep_d;
            kill_en_q     <= kill_en_d;
            kill_mask_q   <= kill_mask_d;
            redir_valid_q <= redir_valid_d;
            redir_pc_q    <= redir_pc_d;
            redir_rob_q   <= redir_rob_d;
            drop_q        <= drop_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            cnt_q         <= cnt_d;
        end
    end

    // NOTE: the storage array has no reset; the occupancy count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (!rst && push_ok) mem_q[wr_ptr_q] <= upd_in;
    end

    assign bru.Alloc_Grant     = grant;
    assign bru.Alloc_Tag       = alloc_tag;
    assign bru.Alloc_Full      = full;
    assign bru.Spectag_Valid   = valid_q;
    assign bru.Kill_Enable     = kill_en_q;
    assign bru.Kill_VKillMask  = kill_mask_q;
    assign bru.Redirect_Valid  = redir_valid_q;
    assign bru.Redirect_PC     = redir_pc_q;
    assign bru.Redirect_RobIdx = redir_rob_q;
    assign bru.Upd_Valid       = (cnt_q != '0);
    assign bru.Upd_Data        = mem_q[rd_ptr_q];
    assign bru.Upd_Drop        = drop_q;
endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter SPEC_STATES, default 4: number of speculation tags, one-hot encoded.
REQ-002 SHALL have parameter ROB_IDX_W, default 6: width of the ROB index.
REQ-003 SHALL have parameter UPD_DEPTH, default 4: predictor-update FIFO depth, a power of 2.
REQ-004 SHALL use one clock and a synchronous, active-high reset, with the following clock and reset ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have these input ports:
- Flush  in  1  pipeline flush.
- Alloc_Req  in  1  decoder requests a speculation tag.
- Resp_Valid  in  1  registered branch-FU response valid.
- Resp_PC  in  64  branch PC.
- Resp_Target  in  64  actual target.
- Resp_Taken  in  1  actual direction.
- Resp_Mispred  in  1  direction or target mispredicted.
- Resp_IsSpec  in  1  branch holds a speculation tag.
- Resp_Spectag  in  SPEC_STATES  branch's tag, one-hot.
- Resp_BrType  in  3  branch type.
- Resp_RobIdx  in  ROB_IDX_W  ROB index.
- Upd_Ready  in  1  predictor accepts an update.
REQ-006 SHALL have these output ports:
- Alloc_Grant  out  1  combinational; tag granted this cycle.
- Alloc_Tag  out  SPEC_STATES  combinational; granted tag, one-hot.
- Alloc_Full  out  1  combinational; no free tag.
- Spectag_Valid  out  SPEC_STATES  registered; live tags.
- Kill_Enable  out  1  registered; kill pulse.
- Kill_VKillMask  out  SPEC_STATES  registered; tags to kill.
- Redirect_Valid  out  1  registered; fetch redirect.
- Redirect_PC  out  64  registered; redirect target.
- Redirect_RobIdx  out  ROB_IDX_W  registered; ROB index of the mispredicted branch.
- Upd_Valid  out  1  FIFO head valid.
- Upd_Data  out  131  FIFO head {PC, Target, Taken, Mispred, BrType}, MSB first.
- Upd_Drop  out  1  registered; update lost because the FIFO was full.

Function
REQ-007 SHALL keep DepMask[i][SPEC_STATES-1:0] for each tag i; bit j set means tag j is older than tag i.
REQ-008 SHALL make Alloc_Tag the lowest-index tag with Spectag_Valid=0.
REQ-009 SHALL make Alloc_Full equal &Spectag_Valid.
REQ-010 SHALL make Alloc_Grant equal Alloc_Req & ~Alloc_Full & ~Flush & ~MispredResolve.
REQ-011 SHALL define a live response as Resp_Valid & Resp_IsSpec & |(Resp_Spectag & Spectag_Valid); a response whose tag is not live SHALL be stale and cause no tag, kill or redirect action.
REQ-012 SHALL define MispredResolve as a live response with Resp_Mispred=1.
REQ-013 SHALL define KillSet as Resp_Spectag | {i : DepMask[i] & Resp_Spectag != 0}, masked with Spectag_Valid.
REQ-014 On grant, SHALL set Spectag_Valid[a] and load DepMask[a] with (Spectag_Valid & ~FreedThisCycle & ~Alloc_Tag) at the next edge.
REQ-015 On a correctly predicted live response, SHALL clear the tag's Spectag_Valid bit and clear that column in every DepMask at the next edge.
REQ-016 On MispredResolve, at the next edge, SHALL clear every bit of KillSet in Spectag_Valid and clear those columns in every DepMask.
REQ-017 On MispredResolve, in the next cycle only, SHALL drive Kill_Enable=1 and Kill_VKillMask=KillSet.
REQ-018 On Resp_Valid & Resp_Mispred with the response not stale (a non-speculative response is never stale), in the next cycle only, SHALL drive Redirect_Valid=1, Redirect_PC={Resp_Target[63:1],0} and Redirect_RobIdx=Resp_RobIdx.
REQ-019 SHALL keep kill and redirect outputs at 0 in every cycle not covered by REQ-017 and REQ-018; their latency SHALL be 1 cycle.
REQ-020 On Resp_Valid with the response not stale, SHALL enqueue the {PC, Target, Taken, Mispred, BrType} update.
REQ-021 If the FIFO is full and no pop occurs, SHALL drop the incoming update and assert Upd_Drop for one cycle.
REQ-022 If the FIFO is full and a pop occurs in the same cycle, SHALL accept the incoming update.
REQ-023 SHALL pop the FIFO when Upd_Valid & Upd_Ready.
REQ-024 SHALL make pointers wrap modulo UPD_DEPTH and SHALL keep an occupancy count 0..UPD_DEPTH.
REQ-025 SHALL let an empty FIFO push and pop in the same cycle: the entry appears at the head one cycle later.
REQ-026 On Flush, at the next edge, SHALL clear Spectag_Valid, every DepMask, Kill_Enable, Kill_VKillMask, Redirect_Valid and Upd_Drop.
REQ-027 Flush SHALL take priority over a same-cycle response or allocation.
REQ-028 Flush SHALL NOT clear the update FIFO.

Reset
REQ-029 While rst=1, at each edge, SHALL clear Spectag_Valid, every DepMask, the FIFO pointers and count, Kill_Enable, Kill_VKillMask, Redirect_Valid, Redirect_PC, Redirect_RobIdx and Upd_Drop to 0.
REQ-030 Reset asserted mid-operation SHALL override every other event in that cycle; Alloc_Grant SHALL read 0 while Spectag_Valid is clear and Alloc_Req=0.

Verification
REQ-031 Allocate three tags in consecutive cycles -> Alloc_Tag 0001, 0010, 0100; Spectag_Valid=0111; DepMask[2]=0011.
REQ-032 Holding REQ-031, mispredict on tag 0010 with Target=0x1003 -> next cycle Kill_Enable=1, Kill_VKillMask=0110, Redirect_PC=0x1002; following edge Spectag_Valid=0001.
REQ-033 Correct resolve on tag 0001 while Alloc_Req=1 in the same cycle with Spectag_Valid=0011 -> grant 0100; next Spectag_Valid=0110, DepMask[2]=0010.
REQ-034 Response on tag 1000 with Spectag_Valid=0001, Resp_Mispred=1 -> no kill, no redirect, no enqueue.
REQ-035 Five responses with Upd_Ready=0 -> four entries held, Upd_Drop=1 on the fifth only; raise Upd_Ready -> entries drain in arrival order.
REQ-036 Flush concurrent with a mispredict on a live tag -> no Kill_Enable, Spectag_Valid=0, FIFO contents unchanged.
